// File: rtl/seq_normalizer.sv
// rtl/seq_normalizer.sv - multi-cycle leading-zero / redundant-sign normalizer
// One left shift per clock until the operand is normalized; returns value and shift count.
module seq_normalizer #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic [SHW-1:0]   shift_amt,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             mode_q, mode_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [SHW-1:0]   shift_amt_q, shift_amt_d;
  logic             zero_q, zero_d;
  logic             normalized;

  // Signed mode is normalized once the top two bits differ (no redundant sign bit left).
  assign normalized = mode_q ? (sr_q[WIDTH-1] ^ sr_q[WIDTH-2]) : sr_q[WIDTH-1];

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    data_out_d  = data_out_q;
    shift_amt_d = shift_amt_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d   = data_in;
          mode_d = mode;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (data_in == '0) begin
            state_d     = DONE;
            done_d      = 1'b1;
            zero_d      = 1'b1;
            data_out_d  = '0;
            shift_amt_d = '0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (normalized) begin
          state_d     = DONE;
          done_d      = 1'b1;
          data_out_d  = sr_q;
          shift_amt_d = cnt_q;
          zero_d      = 1'b0;
        end else begin
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_out_q  <= '0;
      shift_amt_q <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      data_out_q  <= data_out_d;
      shift_amt_q <= shift_amt_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign data_out  = data_out_q;
  assign shift_amt = shift_amt_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// tb/tb_seq_normalizer.sv - self-checking bench for seq_normalizer
// Directed table, held-start and mid-shift reset sequences, then random ops against a model.
module tb_seq_normalizer;

  localparam int W = 8;
  localparam int S = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] data_in;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;
  logic [S-1:0] shift_amt;
  logic         zero;

  int vectors;
  int miscompares;

  typedef struct {
    logic         m;
    logic [W-1:0] d;
    logic [W-1:0] eo;
    int           esh;
    logic         ez;
    int           elat;
  } vec_t;

  vec_t tbl[10];

  seq_normalizer #(.WIDTH(W), .SHW(S)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out), .shift_amt(shift_amt), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: double the value until it leaves the range that still has headroom.
  function automatic void ref_model(input logic m, input logic [W-1:0] d,
                                    output logic [W-1:0] o, output int n, output logic z);
    int v;
    n = 0;
    z = (d == '0);
    if (z) begin
      o = '0;
      return;
    end
    if (!m) begin
      v = int'(d);
      while (v < 2 ** (W - 1)) begin
        v = v * 2;
        n++;
      end
    end else begin
      v = (int'(d) >= 2 ** (W - 1)) ? int'(d) - 2 ** W : int'(d);
      while (v >= -(2 ** (W - 2)) && v <= 2 ** (W - 2) - 1) begin
        v = v * 2;
        n++;
      end
    end
    o = W'(v);
  endfunction

  task automatic run_op(input logic m, input logic [W-1:0] d, input logic [W-1:0] eo,
                        input int esh, input logic ez, input int elat, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " idle_before"}, int'(busy), 0);
    start = 1'b1;
    mode = m;
    data_in = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = ~m;
    data_in = W'($urandom);
    chk({tag, " busy_after_accept"}, int'(busy), 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " data_out"}, int'(data_out), int'(eo));
    chk({tag, " shift_amt"}, int'(shift_amt), esh);
    chk({tag, " zero"}, int'(zero), int'(ez));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, int'(done), 0);
    chk({tag, " busy_released"}, int'(busy), 0);
  endtask

  initial begin
    logic [W-1:0] eo;
    int           en;
    logic         ez;
    int           pulses;
    logic [W-1:0] p_out[2];
    int           p_sh[2];
    logic         seen_idle;
    logic         changed;

    vectors = 0;
    miscompares = 0;
    start = 1'b0;
    mode = 1'b0;
    data_in = '0;

    tbl[0] = '{1'b0, 8'h0F, 8'hF0, 4, 1'b0, 6};
    tbl[1] = '{1'b1, 8'hF0, 8'h80, 3, 1'b0, 5};
    tbl[2] = '{1'b1, 8'h0F, 8'h78, 3, 1'b0, 5};
    tbl[3] = '{1'b0, 8'h01, 8'h80, 7, 1'b0, 9};
    tbl[4] = '{1'b1, 8'hFF, 8'h80, 7, 1'b0, 9};
    tbl[5] = '{1'b0, 8'h81, 8'h81, 0, 1'b0, 2};
    tbl[6] = '{1'b0, 8'h00, 8'h00, 0, 1'b1, 1};
    tbl[7] = '{1'b1, 8'h00, 8'h00, 0, 1'b1, 1};
    tbl[8] = '{1'b0, 8'h0F, 8'hF0, 4, 1'b0, 6};
    tbl[9] = '{1'b1, 8'h40, 8'h40, 0, 1'b0, 2};

    rst = 1'b1;
    #3;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset data_out", int'(data_out), 0);
    chk("reset shift_amt", int'(shift_amt), 0);
    chk("reset zero", int'(zero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].m, tbl[i].d, tbl[i].eo, tbl[i].esh, tbl[i].ez, tbl[i].elat,
             $sformatf("tbl%0d", i));

    // start held high: inputs changed while busy must not leak into either result
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    data_in = 8'h81;
    @(posedge clk);
    #1;
    data_in = 8'h0F;
    pulses = 0;
    seen_idle = 1'b0;
    changed = 1'b0;
    for (int c = 0; c < 40 && pulses < 2; c++) begin
      @(negedge clk);
      if (done) begin
        p_out[pulses] = data_out;
        p_sh[pulses] = int'(shift_amt);
        pulses++;
      end
      if (!busy) seen_idle = 1'b1;
      if (seen_idle && busy && !changed) begin
        data_in = 8'h55;
        mode = 1'b1;
        changed = 1'b1;
      end
    end
    start = 1'b0;
    chk("held pulses", pulses, 2);
    chk("held first data_out", int'(p_out[0]), 8'h81);
    chk("held first shift_amt", p_sh[0], 0);
    chk("held second data_out", int'(p_out[1]), 8'hF0);
    chk("held second shift_amt", p_sh[1], 4);
    repeat (2) @(negedge clk);
    chk("held no third accept", int'(busy), 0);

    // reset after three SHIFT edges aborts silently
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    data_in = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst data_out", int'(data_out), 0);
    chk("midrst shift_amt", int'(shift_amt), 0);
    chk("midrst zero", int'(zero), 0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("midrst no done", pulses, 0);
    run_op(1'b0, 8'h0F, 8'hF0, 4, 1'b0, 6, "after_rst");

    for (int i = 0; i < 60; i++) begin
      logic         m;
      logic [W-1:0] d;
      int           sel;
      m = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0) d = '0;
      else if (sel == 1) d = '1;
      else d = W'($urandom);
      ref_model(m, d, eo, en, ez);
      run_op(m, d, eo, en, ez, ez ? 1 : en + 2, $sformatf("rnd%0d m%0d d%02h", i, m, d));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
